// File: rtl/fpu_cp_pkg.sv
// Shared definitions for the FPU coprocessor issue unit: opcodes, instruction
// field positions, FSM state encoding and opcode classification helpers.
package fpu_cp_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned IN1_MSB  = 25;
    localparam int unsigned IN1_LSB  = 21;
    localparam int unsigned IN2_MSB  = 20;
    localparam int unsigned IN2_LSB  = 16;
    localparam int unsigned DEST_MSB = 15;
    localparam int unsigned DEST_LSB = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    function automatic logic is_legal(input logic [5:0] opc);
        return (opc >= OP_ADD) && (opc <= OP_SW);
    endfunction

    function automatic logic is_arith(input logic [5:0] opc);
        return (opc >= OP_ADD) && (opc <= OP_RND);
    endfunction

endpackage

// File: rtl/fpu_cp_decode.sv
// Combinational opcode classifier: legal coprocessor op, arithmetic, load, store.
module fpu_cp_decode
    import fpu_cp_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       legal,
    output logic       arith,
    output logic       lw,
    output logic       sw
);

    always_comb begin
        legal = is_legal(opcode);
        arith = is_arith(opcode);
        lw    = (opcode == OP_LW);
        sw    = (opcode == OP_SW);
    end

endmodule

// File: rtl/fpu_cp_issue.sv
// CPU-side issue unit for the FPU coprocessor: accepts instruction words,
// presents each op for one coprocessor edge, and returns sw results to writeback.
module fpu_cp_issue
    import fpu_cp_pkg::*;
#(
    parameter int unsigned OP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] instr_data,
    output logic [5:0]  cp_opcode,
    output logic [4:0]  cp_addr_in1,
    output logic [4:0]  cp_addr_in2,
    output logic [4:0]  cp_addr_dest,
    output logic [31:0] cp_indata,
    input  logic [31:0] cp_outdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        illegal
);

    localparam int unsigned CNT_W   = $clog2(OP_LATENCY + 1);
    localparam logic        LONG_OP = (OP_LATENCY > 1);

    state_t           state;
    state_t           iss_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             dec_legal;
    logic             dec_arith;
    logic             dec_lw;
    logic             dec_sw;
    logic             unused_instr_bits;

    fpu_cp_decode u_decode (
        .opcode (instr[OPC_MSB:OPC_LSB]),
        .legal  (dec_legal),
        .arith  (dec_arith),
        .lw     (dec_lw),
        .sw     (dec_sw)
    );

    always_comb begin
        instr_ready       = (state == ST_IDLE);
        accept            = instr_valid && instr_ready;
        unused_instr_bits = ^instr[DEST_LSB-1:0];
    end

    // The post-ISSUE destination is resolved at accept time so ISSUE needs no decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            iss_next     <= ST_IDLE;
            cnt          <= '0;
            cp_opcode    <= OP_NOP;
            cp_addr_in1  <= '0;
            cp_addr_in2  <= '0;
            cp_addr_dest <= '0;
            cp_indata    <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            illegal      <= 1'b0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            cp_opcode    <= instr[OPC_MSB:OPC_LSB];
                            cp_addr_in1  <= instr[IN1_MSB:IN1_LSB];
                            cp_addr_in2  <= instr[IN2_MSB:IN2_LSB];
                            cp_addr_dest <= instr[DEST_MSB:DEST_LSB];
                            cp_indata    <= instr_data;
                            if (dec_sw)
                                iss_next <= ST_CAPTURE;
                            else if (dec_lw)
                                iss_next <= ST_IDLE;
                            else if (dec_arith && LONG_OP)
                                iss_next <= ST_WAIT;
                            else
                                iss_next <= ST_IDLE;
                            state <= ST_ISSUE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    cp_opcode <= OP_NOP;
                    state     <= iss_next;
                    if (iss_next == ST_WAIT)
                        cnt <= CNT_W'(OP_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    wb_data  <= cp_outdata;
                    wb_valid <= 1'b1;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cp_issue.sv
// Bench for fpu_cp_issue: two instances (OP_LATENCY 3 and 1) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_fpu_cp_issue;

    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] ADD = 6'b110000;
    localparam logic [5:0] SUB = 6'b110001;
    localparam logic [5:0] MUL = 6'b110010;
    localparam logic [5:0] RND = 6'b110110;
    localparam logic [5:0] LW  = 6'b110111;
    localparam logic [5:0] SW  = 6'b111000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  iv;
    logic [31:0] instr;
    logic [31:0] idata;
    logic        wb_ready;

    logic        rdy   [2];
    logic [5:0]  cp_op [2];
    logic [4:0]  a1    [2];
    logic [4:0]  a2    [2];
    logic [4:0]  ad    [2];
    logic [31:0] ind   [2];
    logic [31:0] outd  [2] = '{default: '0};
    logic        wbv   [2];
    logic [31:0] wbd   [2];
    logic        ill   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_cp_issue #(.OP_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .instr_valid(iv[0]), .instr_ready(rdy[0]),
        .instr(instr), .instr_data(idata), .cp_opcode(cp_op[0]),
        .cp_addr_in1(a1[0]), .cp_addr_in2(a2[0]), .cp_addr_dest(ad[0]),
        .cp_indata(ind[0]), .cp_outdata(outd[0]), .wb_valid(wbv[0]),
        .wb_data(wbd[0]), .wb_ready(wb_ready), .illegal(ill[0])
    );

    fpu_cp_issue #(.OP_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .instr_valid(iv[1]), .instr_ready(rdy[1]),
        .instr(instr), .instr_data(idata), .cp_opcode(cp_op[1]),
        .cp_addr_in1(a1[1]), .cp_addr_in2(a2[1]), .cp_addr_dest(ad[1]),
        .cp_indata(ind[1]), .cp_outdata(outd[1]), .wb_valid(wbv[1]),
        .wb_data(wbd[1]), .wb_ready(wb_ready), .illegal(ill[1])
    );

    // Coprocessor stand-in: lw writes reg[in1], sw registers reg[in1] onto outdata.
    logic [31:0] cregs [2][32] = '{default: '0};
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cp_op[k] == LW) cregs[k][a1[k]] <= ind[k];
            else if (cp_op[k] == SW) outd[k] <= cregs[k][a1[k]];
        end
    end

    // Transaction-level model: cycles of occupancy, pending sw result, outputs.
    typedef struct packed {
        logic [7:0]  busy;
        logic        resp;
        logic        swpend;
        logic [31:0] swval;
        logic [5:0]  op;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [31:0] ind;
        logic        wbv;
        logic [31:0] wbd;
        logic        ill;
    } mstate_t;

    mstate_t     ms     [2];
    logic [31:0] shadow [2][32];

    function automatic logic [7:0] lat_of(input int k);
        return (k == 0) ? 8'd3 : 8'd1;
    endfunction

    function automatic logic m_ready(input mstate_t s);
        return (s.busy == 8'd0) && !s.resp;
    endfunction

    function automatic mstate_t rst_ms();
        mstate_t n;
        n = '0;
        n.op = NOP;
        return n;
    endfunction

    function automatic mstate_t next_ms(input mstate_t s, input logic [7:0] lat,
                                        input logic v, input logic [31:0] ins,
                                        input logic [31:0] dat, input logic wr,
                                        input logic [31:0] sh_rd);
        mstate_t    n;
        logic [5:0] opc;
        n = s;
        n.op  = NOP;
        n.ill = 1'b0;
        if (s.resp && wr) begin
            n.resp = 1'b0;
            n.wbv  = 1'b0;
        end
        if (s.busy > 0) begin
            n.busy = s.busy - 8'd1;
            if (n.busy == 0 && s.swpend) begin
                n.swpend = 1'b0;
                n.resp   = 1'b1;
                n.wbv    = 1'b1;
                n.wbd    = s.swval;
            end
        end
        if (m_ready(s) && v) begin
            opc = ins[31:26];
            if (opc < ADD || opc > SW) begin
                n.ill = 1'b1;
            end else begin
                n.op  = opc;
                n.a1  = ins[25:21];
                n.a2  = ins[20:16];
                n.ad  = ins[15:11];
                n.ind = dat;
                if (opc == LW) begin
                    n.busy = 8'd1;
                end else if (opc == SW) begin
                    n.busy   = 8'd2;
                    n.swpend = 1'b1;
                    n.swval  = sh_rd;
                end else begin
                    n.busy = lat;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) ms[k] <= rst_ms();
        end else begin
            for (int k = 0; k < 2; k++) begin
                ms[k] <= next_ms(ms[k], lat_of(k), iv[k], instr, idata, wb_ready,
                                 shadow[k][instr[25:21]]);
                if (m_ready(ms[k]) && iv[k] && instr[31:26] == LW)
                    shadow[k][instr[25:21]] <= idata;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m_ready%0d", k), 32'(rdy[k]), 32'(m_ready(ms[k])));
                chk($sformatf("m_op%0d", k), 32'(cp_op[k]), 32'(ms[k].op));
                chk($sformatf("m_a1_%0d", k), 32'(a1[k]), 32'(ms[k].a1));
                chk($sformatf("m_a2_%0d", k), 32'(a2[k]), 32'(ms[k].a2));
                chk($sformatf("m_ad%0d", k), 32'(ad[k]), 32'(ms[k].ad));
                chk($sformatf("m_ind%0d", k), ind[k], ms[k].ind);
                chk($sformatf("m_wbv%0d", k), 32'(wbv[k]), 32'(ms[k].wbv));
                chk($sformatf("m_wbd%0d", k), wbd[k], ms[k].wbd);
                chk($sformatf("m_ill%0d", k), 32'(ill[k]), 32'(ms[k].ill));
            end
        end
    end

    logic       rec_on = 1'b0;
    logic [5:0] rec_op  [$];
    int         rec_cyc [$];
    always @(negedge clk) begin
        if (rec_on && cp_op[1] != NOP) begin
            rec_op.push_back(cp_op[1]);
            rec_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] x,
                                       input logic [4:0] y, input logic [4:0] d);
        return {o, x, y, d, 11'd0};
    endfunction

    task automatic send(input int k, input logic [31:0] ins, input logic [31:0] dat);
        int t;
        @(negedge clk);
        instr = ins;
        idata = dat;
        iv[k] = 1'b1;
        t = 0;
        while (!rdy[k] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("accept_timeout", 32'(rdy[k]), 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (!(rdy[k] && !wbv[k]) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("idle_timeout", 32'(rdy[k]), 32'd1);
    endtask

    initial begin
        int t;
        rst = 1'b1; iv = 2'b00; instr = '0; idata = '0; wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy[1]), 32'd1);
        chk("rst_op", 32'(cp_op[0]), 32'(NOP));
        chk("rst_wbv", 32'(wbv[0]), 32'd0);
        chk("rst_wbd", wbd[1], 32'd0);
        rst = 1'b0;

        // lw: one-cycle issue with operands, then NOP and ready again
        send(1, mk(LW, 5'd3, 5'd0, 5'd0), 32'h3F800000);
        @(negedge clk); iv = 2'b00;
        chk("lw_op", 32'(cp_op[1]), 32'(LW));
        chk("lw_in1", 32'(a1[1]), 32'd3);
        chk("lw_data", ind[1], 32'h3F800000);
        chk("lw_rdy_n1", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        chk("lw_nop", 32'(cp_op[1]), 32'(NOP));
        chk("lw_rdy_n2", 32'(rdy[1]), 32'd1);

        // lw then sw with stalled writeback
        send(1, mk(LW, 5'd3, 5'd0, 5'd0), 32'h40490FDB);
        @(negedge clk); iv = 2'b00;
        wb_ready = 1'b0;
        send(1, mk(SW, 5'd3, 5'd0, 5'd0), 32'h0);
        @(negedge clk); iv = 2'b00;
        chk("sw_op", 32'(cp_op[1]), 32'(SW));
        chk("sw_wbv_n1", 32'(wbv[1]), 32'd0);
        @(negedge clk);
        chk("sw_wbv_n2", 32'(wbv[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_wbv_stall", 32'(wbv[1]), 32'd1);
            chk("sw_wbd_stall", wbd[1], 32'h40490FDB);
            chk("sw_rdy_stall", 32'(rdy[1]), 32'd0);
        end
        @(negedge clk);
        wb_ready = 1'b1;
        chk("sw_wbv_last", 32'(wbv[1]), 32'd1);
        @(negedge clk);
        chk("sw_wbv_clr", 32'(wbv[1]), 32'd0);
        chk("sw_rdy_back", 32'(rdy[1]), 32'd1);

        // OP_LATENCY=3 add, second op held valid during the wait
        send(0, mk(ADD, 5'd1, 5'd2, 5'd4), 32'h0);
        @(negedge clk);
        instr = mk(SUB, 5'd5, 5'd6, 5'd7);
        chk("add_op", 32'(cp_op[0]), 32'(ADD));
        chk("add_in1", 32'(a1[0]), 32'd1);
        chk("add_in2", 32'(a2[0]), 32'd2);
        chk("add_dest", 32'(ad[0]), 32'd4);
        chk("add_rdy_n1", 32'(rdy[0]), 32'd0);
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            chk("add_nop_wait", 32'(cp_op[0]), 32'(NOP));
            chk("add_rdy_wait", 32'(rdy[0]), 32'd0);
        end
        @(negedge clk);
        chk("add_rdy_n4", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        @(negedge clk); iv = 2'b00;
        chk("sub_op", 32'(cp_op[0]), 32'(SUB));
        chk("sub_in1", 32'(a1[0]), 32'd5);
        wait_idle(0);

        // illegal opcode: pulse only, coprocessor outputs untouched
        send(1, mk(6'b000111, 5'd9, 5'd9, 5'd9), 32'hDEADBEEF);
        @(negedge clk); iv = 2'b00;
        chk("ill_pulse", 32'(ill[1]), 32'd1);
        chk("ill_op", 32'(cp_op[1]), 32'(NOP));
        chk("ill_rdy", 32'(rdy[1]), 32'd1);
        chk("ill_in1_held", 32'(a1[1]), 32'd3);
        @(negedge clk);
        chk("ill_clr", 32'(ill[1]), 32'd0);

        // reset while a sw result waits in RESP
        wb_ready = 1'b0;
        send(1, mk(SW, 5'd3, 5'd0, 5'd0), 32'h0);
        @(negedge clk); iv = 2'b00;
        repeat (2) @(negedge clk);
        chk("rr_wbv_pre", 32'(wbv[1]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rr_wbv_async", 32'(wbv[1]), 32'd0);
        chk("rr_op_async", 32'(cp_op[1]), 32'(NOP));
        #1 rst = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("rr_ready", 32'(rdy[1]), 32'd1);
        chk("rr_wbd", wbd[1], 32'd0);
        chk("rr_in1", 32'(a1[1]), 32'd0);
        chk("rr_indata", ind[1], 32'd0);

        // back-to-back lw, mul, rnd, sw with valid held high
        rec_on = 1'b1;
        send(1, mk(LW, 5'd5, 5'd0, 5'd0), 32'hC0000000);
        send(1, mk(MUL, 5'd1, 5'd2, 5'd3), 32'h0);
        send(1, mk(RND, 5'd4, 5'd0, 5'd6), 32'h0);
        send(1, mk(SW, 5'd5, 5'd0, 5'd0), 32'h0);
        @(negedge clk); iv = 2'b00;
        t = 0;
        while (!wbv[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_wbv", 32'(wbv[1]), 32'd1);
        chk("b2b_wbd", wbd[1], 32'hC0000000);
        rec_on = 1'b0;
        chk("b2b_count", 32'(rec_op.size()), 32'd4);
        if (rec_op.size() == 4) begin
            chk("b2b_op0", 32'(rec_op[0]), 32'(LW));
            chk("b2b_op1", 32'(rec_op[1]), 32'(MUL));
            chk("b2b_op2", 32'(rec_op[2]), 32'(RND));
            chk("b2b_op3", 32'(rec_op[3]), 32'(SW));
            for (int i = 1; i < 4; i++)
                chk("b2b_gap", 32'(rec_cyc[i] - rec_cyc[i-1]), 32'd2);
        end
        wait_idle(1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_cp_issue.md
# fpu_cp_issue

CPU-side issue unit that drives the floating-point coprocessor port. It accepts coprocessor instruction words from the main pipeline over a valid/ready handshake and decodes them into the coprocessor's opcode, register-address and load-data inputs. It presents each operation for exactly one coprocessor clock edge, and for stores (sw) captures `outdata_float` and returns it to the pipeline's writeback stage over a second valid/ready handshake. It is the initiator for the coprocessor, which acts as the responder.

## Interface
- `OP_LATENCY`, default 1: coprocessor edges an arithmetic op (add/sub/mul/div/cmp/rev/rnd) occupies before the next op may issue; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  pipeline presents an instruction.
- `instr_ready`  out  1  unit can accept; high only in IDLE.
- `instr`  in  32  fields: [31:26] opcode, [25:21] in1, [20:16] in2, [15:11] dest.
- `instr_data`  in  32  load value for lw; sampled at accept.
- `cp_opcode`  out  6  to coprocessor `opcode`; NOP = 6'b000000 when idle.
- `cp_addr_in1`, `cp_addr_in2`, `cp_addr_dest`  out  5 each  to coprocessor register addresses.
- `cp_indata`  out  32  to coprocessor `inputdata_float`.
- `cp_outdata`  in  32  from coprocessor `outdata_float`.
- `wb_valid`  out  1  sw result available.
- `wb_data`  out  32  sw result.
- `wb_ready`  in  1  writeback consumes result.
- `illegal`  out  1  one-cycle pulse on an accepted non-coprocessor opcode.

## Operation
- Legal opcodes: 110000 add, 110001 sub, 110010 mul, 110011 div, 110100 cmp, 110101 rev, 110110 rnd, 110111 lw, 111000 sw. All other opcodes are illegal.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE: `instr_ready`=1; `cp_opcode`=NOP.
  - Accept = `instr_valid && instr_ready`.
  - Legal accept: register opcode, address fields and `instr_data` onto the `cp_*` outputs → ISSUE.
  - Illegal accept: `illegal` pulses in the next cycle; the `cp_*` outputs are unchanged; FSM stays in IDLE.
- ISSUE (exactly one cycle): `cp_opcode` = the decoded op.
  - sw → CAPTURE.
  - lw → IDLE.
  - Arithmetic → IDLE if `OP_LATENCY`==1, else WAIT with counter = `OP_LATENCY`-1.
- WAIT: `cp_opcode`=NOP; decrement the counter each cycle; at 1 → IDLE.
- CAPTURE: `cp_opcode`=NOP; latch `cp_outdata` into `wb_data` → RESP.
- RESP: `wb_valid`=1; `wb_data` held stable until `wb_ready`; on `wb_valid && wb_ready` → IDLE in the same edge.
- Address and data outputs hold their last issued values outside ISSUE. Only `cp_opcode` is forced to NOP.

## Timing
- Reset values: state IDLE, `cp_opcode`=NOP, all addresses 0, `cp_indata`=0, `wb_data`=0, `wb_valid`=0, `illegal`=0, counter 0.
- `instr_ready` reflects IDLE combinationally from state, so it is 1 immediately after reset deassertion.
- Accept at edge N: `cp_opcode` is valid for cycle N+1 only; the coprocessor executes at edge N+1.
- lw / arithmetic with `OP_LATENCY`=1: `instr_ready` is high again in cycle N+2, giving a throughput of one op per 2 cycles.
- Arithmetic with `OP_LATENCY`=L: `instr_ready` is high in cycle N+1+L.
- sw: `cp_outdata` is captured at edge N+2; `wb_valid` rises in cycle N+3. With `wb_ready` already high, `instr_ready` returns in cycle N+4.
- The issue order is the program order. A sw after a lw to the same register sees the loaded value, because the coprocessor has already updated that register at the lw's issue edge.
- `rst` asserted in any state aborts the operation at once: any pending `wb_data` is discarded and `cp_opcode` returns to NOP asynchronously.
- An `instr_valid` that is high outside IDLE is ignored, and the instruction is not consumed.

## Structure
- Package `fpu_cp_pkg`: the opcode localparams (including NOP), instruction field bit positions, the FSM state enum, and an `is_legal`/`is_arith` classification function.
- One sub-module, `fpu_cp_decode`: a combinational opcode-to-class decoder (legal, arith, lw, sw). The FSM, counter and result register live in `fpu_cp_issue`.

## Test plan
- lw: `instr`={110111,5'd3,0,0,...}, `instr_data`=32'h3F800000 → cycle N+1 shows `cp_opcode`=110111, `cp_addr_in1`=3, `cp_indata`=32'h3F800000; cycle N+2 shows NOP and `instr_ready`=1.
- lw r3 = 32'h40490FDB, then sw r3 with `wb_ready` held low 4 cycles → `wb_valid` rises in cycle N+3 with `wb_data`=32'h40490FDB, held stable through the stall, then cleared the cycle after `wb_ready`.
- `OP_LATENCY`=3, add in1=1 in2=2 dest=4 → `cp_opcode`=110000 for exactly one cycle; `instr_ready` low for cycles N+1..N+3 and high in N+4; a second `instr_valid` held during the wait is accepted only in N+4.
- Illegal opcode 6'b000111 → `illegal`=1 in cycle N+1 only; `cp_opcode` stays NOP; `instr_ready` stays 1.
- sw issued, `rst` pulsed in RESP → `wb_valid`=0 and `cp_opcode`=NOP immediately; after release, `instr_ready`=1 and all outputs are at their reset values.
- Back-to-back lw, mul, rnd, sw with `instr_valid` held high → each op is issued exactly once in order, with one NOP cycle between consecutive issues.
